// File: rtl/instr_mem_loader_pkg.sv
// Shared instruction-memory geometry and the loader FSM state encoding.
package pkg_imem;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in the MSBs; word_ready_o on the last byte's handshake.
// Zero latency on word_ready_o; no backpressure of its own (the caller gates shift_i).
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_ready_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_comb begin
    idx_d        = idx_q;
    buf_d        = buf_q;
    word_ready_o = shift_i && (idx_q == LAST_IDX);
    if (clr_i) begin
      idx_d = '0;
      buf_d = '0;
    end else if (shift_i) begin
      buf_d = (buf_q << 8) | DATA_W'(byte_i);
      idx_d = word_ready_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  assign word_o = buf_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory as big-endian words, holding the CPU in reset meanwhile.
// One write cycle after every 4th accepted byte; byte_ready drops outside COLLECT and during abort.
module instr_mem_loader
  import pkg_imem::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_written,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   limit_q, limit_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic              start_ok;
  logic              shift;
  logic              word_ready;
  logic [DATA_W-1:0] word;
  logic [ADDR_W:0]   wcnt_inc;

  assign start_ok   = start && !abort && (state_q == IDLE || state_q == DONE);
  assign byte_ready = (state_q == COLLECT) && !abort;
  assign shift      = byte_valid && byte_ready;
  assign wcnt_inc   = wcnt_q + (ADDR_W + 1)'(1);

  byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (abort || start_ok),
    .shift_i     (shift),
    .byte_i      (byte_in),
    .word_o      (word),
    .word_ready_o(word_ready)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    limit_d = limit_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    if (abort) begin
      // Counters survive an abort so software can inspect how far the load got.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            wcnt_d  = '0;
            csum_d  = '0;
            addr_d  = BASE;
            limit_d = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
            state_d = (num_words == '0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (word_ready) state_d = WRITE;
        end
        WRITE: begin
          addr_d  = addr_q + ADDR_W'(1);
          wcnt_d  = wcnt_inc;
          csum_d  = csum_q + word;
          state_d = (wcnt_inc == limit_q) ? DONE : COLLECT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      limit_q <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
    end
  end

  assign mem_we        = (state_q == WRITE) && !abort;
  assign mem_addr      = addr_q;
  assign mem_din       = word;
  assign busy          = (state_q == COLLECT) || (state_q == WRITE);
  assign cpu_hold      = busy;
  assign done          = (state_q == DONE);
  assign words_written = wcnt_q;
  assign checksum      = csum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised scoreboard bench for instr_mem_loader: expected writes are queued as words are sent.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] num_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, busy, done, cpu_hold;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, checksum;
  logic [10:0] words_written;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          busy_seen = 1'b0;
  logic [31:0] model_sum;
  int          model_addr;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy),
    .done(done), .cpu_hold(cpu_hold), .words_written(words_written), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && busy) busy_seen = 1'b1;
    if (rst_n && mem_we) begin
      check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {54'd0, mem_addr}, 64'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data) begin
          check("write_addr", {54'd0, mem_addr}, {54'd0, e.addr});
          check("write_data", {32'd0, mem_din}, {32'd0, e.data});
        end else begin
          total++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; abort = 0; byte_valid = 0; byte_in = '0; num_words = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    num_words = 11'(n);
    @(posedge clk); #1;
    start = 1'b0;
    model_sum = '0;
    model_addr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in = b;
    t = 0;
    @(negedge clk);
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Reference: each sent word goes to the next sequential address and adds into the sum.
  task automatic send_word(input logic [31:0] w, input int gap);
    wr_t e;
    e.addr = 10'(model_addr);
    e.data = w;
    exp_q.push_back(e);
    model_addr = (model_addr + 1) % 1024;
    model_sum = model_sum + w;
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) check("done_timeout", 64'd0, 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] w;

    do_reset();
    check("rst_mem_we", {63'd0, mem_we}, 0);
    check("rst_mem_addr", {54'd0, mem_addr}, 0);
    check("rst_busy_done_hold_ready", {60'd0, busy, done, cpu_hold, byte_ready}, 0);
    check("rst_words", {53'd0, words_written}, 0);
    check("rst_checksum", {32'd0, checksum}, 0);

    // Single word, back-to-back bytes.
    pulse_start(1);
    check("busy_after_start", {62'd0, busy, cpu_hold}, 64'd3);
    c0 = cyc;
    send_word(32'hDEADBEEF, 0);
    check("single_cycles", 64'(cyc - c0), 64'd4);
    check("single_we_timing", {63'd0, mem_we}, 64'd1);
    wait_done(20);
    check("single_words", {53'd0, words_written}, 64'd1);
    check("single_checksum", {32'd0, checksum}, 64'hDEADBEEF);
    check("single_hold", {63'd0, cpu_hold}, 64'd0);

    // Three words, byte_valid toggling; a start while busy must be ignored.
    pulse_start(3);
    send_byte(8'h11, 1);
    start = 1'b1; num_words = 11'd1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back('{addr: 10'd0, data: 32'h11223344});
    model_addr = 1;
    model_sum = 32'h11223344;
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    for (int i = 0; i < 2; i++) send_word($urandom, 1);
    wait_done(60);
    check("three_words", {53'd0, words_written}, 64'd3);
    check("three_checksum", {32'd0, checksum}, {32'd0, model_sum});

    // num_words = 0.
    busy_seen = 1'b0;
    pulse_start(0);
    check("zero_done", {63'd0, done}, 64'd1);
    repeat (3) @(posedge clk); #1;
    check("zero_busy_never", {63'd0, busy_seen}, 64'd0);
    check("zero_words", {53'd0, words_written}, 64'd0);
    check("zero_checksum", {32'd0, checksum}, 64'd0);

    // Abort after 2 bytes of the second word.
    pulse_start(3);
    send_word(32'h00000013, 0);
    send_byte($urandom, 0); send_byte($urandom, 0);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("abort_state", {61'd0, busy, done, byte_ready}, 64'd0);
    check("abort_words", {53'd0, words_written}, 64'd1);
    check("abort_checksum", {32'd0, checksum}, 64'h13);
    pulse_start(2);
    check("restart_addr", {54'd0, mem_addr}, 64'd0);
    for (int i = 0; i < 2; i++) send_word($urandom, 0);
    wait_done(20);
    check("restart_words", {53'd0, words_written}, 64'd2);
    check("restart_checksum", {32'd0, checksum}, {32'd0, model_sum});

    // 1025 requested words saturate to a full memory image.
    pulse_start(1025);
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      send_word(w, (i % 97 == 5) ? 2 : 0);
    end
    wait_done(20);
    repeat (3) @(posedge clk); #1;
    check("full_done", {63'd0, done}, 64'd1);
    check("full_words", {53'd0, words_written}, 64'd1024);
    check("full_checksum", {32'd0, checksum}, {32'd0, model_sum});
    check("full_addr_wrap", {54'd0, mem_addr}, 64'd0);

    // Asynchronous reset mid-COLLECT.
    pulse_start(1);
    send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flags", {59'd0, busy, done, cpu_hold, byte_ready, mem_we}, 0);
    check("async_rst_words", {53'd0, words_written}, 0);
    check("async_rst_addr", {54'd0, mem_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(1);
    send_word($urandom, 0);
    wait_done(20);
    check("post_rst_words", {53'd0, words_written}, 64'd1);
    check("post_rst_checksum", {32'd0, checksum}, {32'd0, model_sum});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
